alu_dot8_share_arb: RTL

Shares one DOT8 processing element among `NUM_REQS` ALU blocks. It sits between each block's PE switch DOT8 port and a single shared DOT8 unit. Requests are granted round-robin and the requester index is recorded in an in-order tag FIFO. Each in-order PE response is steered back to the block that issued the request.

---
 rtl/alu_dot8_share_arb_pkg.sv | 17 +
 rtl/alu_dot8_share_arb_if.sv | 41 ++++
 rtl/alu_dot8_share_arb_fifo.sv | 65 ++++++
 rtl/alu_dot8_share_arb.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/alu_dot8_share_arb_pkg.sv
// Shared constants and helpers for the DOT8 sharing arbiter.
package alu_dot8_share_arb_pkg;

   localparam int unsigned PERF_W           = 32;
   localparam int unsigned NUM_REQS_DEF     = 4;
   localparam int unsigned DATAW_DEF        = 256;
   localparam int unsigned RSPW_DEF         = 128;
   localparam int unsigned MAX_INFLIGHT_DEF = 4;

   typedef logic [PERF_W-1:0] perf_cnt_t;

   // Width of a requester index; never narrower than one bit.
   function automatic int unsigned sel_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/alu_dot8_share_arb_if.sv
// Bundle of the ALU-side and DOT8-side handshakes of the sharing arbiter.
interface alu_dot8_share_arb_if #(
   parameter int unsigned NUM_REQS = alu_dot8_share_arb_pkg::NUM_REQS_DEF,
   parameter int unsigned DATAW    = alu_dot8_share_arb_pkg::DATAW_DEF,
   parameter int unsigned RSPW     = alu_dot8_share_arb_pkg::RSPW_DEF
) ();
   import alu_dot8_share_arb_pkg::*;

   logic [NUM_REQS-1:0]       req_valid;
   logic [NUM_REQS*DATAW-1:0] req_data;
   logic [NUM_REQS-1:0]       req_ready;

   logic                      pe_req_valid;
   logic [DATAW-1:0]          pe_req_data;
   logic                      pe_req_ready;

   logic                      pe_rsp_valid;
   logic [RSPW-1:0]           pe_rsp_data;
   logic                      pe_rsp_ready;

   logic [NUM_REQS-1:0]       rsp_valid;
   logic [RSPW-1:0]           rsp_data;
   logic [NUM_REQS-1:0]       rsp_ready;

   perf_cnt_t                 perf_stalls;

   // Arbiter view.
   modport slave (
      input  req_valid, req_data, pe_req_ready, pe_rsp_valid, pe_rsp_data, rsp_ready,
      output req_ready, pe_req_valid, pe_req_data, pe_rsp_ready, rsp_valid, rsp_data,
             perf_stalls
   );

   // Environment view (ALU blocks plus DOT8 unit).
   modport master (
      output req_valid, req_data, pe_req_ready, pe_rsp_valid, pe_rsp_data, rsp_ready,
      input  req_ready, pe_req_valid, pe_req_data, pe_rsp_ready, rsp_valid, rsp_data,
             perf_stalls
   );

endinterface

// File: rtl/alu_dot8_share_arb_fifo.sv
// In-order tag FIFO recording which requester owns each outstanding DOT8 op.
module alu_dot8_share_arb_fifo
   import alu_dot8_share_arb_pkg::*;
#(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic [WIDTH-1:0]             data_i,
   output logic [WIDTH-1:0]             data_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH):0]       count_o
);

   localparam int unsigned PTRW = $clog2(DEPTH);
   localparam int unsigned CNTW = PTRW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]  count_q,  count_d;
   logic             do_push,  do_pop;

   // Qualify push/pop against the current occupancy and advance pointers.
   always_comb begin
      do_push  = push_i && (count_q != CNTW'(DEPTH));
      do_pop   = pop_i && (count_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTRW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTRW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNTW'(1);
         2'b01:   count_d = count_q - CNTW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Tag storage; contents are don't-care while the slot is unoccupied.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/alu_dot8_share_arb.sv
// Round-robin sharing of one DOT8 unit among several ALU blocks with in-order response steering.
module alu_dot8_share_arb
   import alu_dot8_share_arb_pkg::*;
#(
   parameter int unsigned NUM_REQS     = NUM_REQS_DEF,
   parameter int unsigned DATAW        = DATAW_DEF,
   parameter int unsigned RSPW         = RSPW_DEF,
   parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   alu_dot8_share_arb_if.slave   bus
);

   localparam int unsigned REQ_SELW = sel_width(NUM_REQS);
   localparam int unsigned CNTW     = $clog2(MAX_INFLIGHT) + 1;

   logic [REQ_SELW-1:0] rr_ptr_q,   rr_ptr_d;
   logic                locked_q,   locked_d;
   logic [REQ_SELW-1:0] lock_idx_q, lock_idx_d;
   perf_cnt_t           perf_q,     perf_d;

   logic [REQ_SELW-1:0] rr_idx;
   logic [REQ_SELW-1:0] cand;
   logic                rr_hit;
   logic [REQ_SELW-1:0] sel_idx;
   logic [REQ_SELW-1:0] next_ptr;
   logic                credit_ok;
   logic                pe_req_valid_c;
   logic                req_fire;
   logic                rsp_ok;
   logic                pe_rsp_ready_c;
   logic                rsp_fire;
   logic [REQ_SELW-1:0] head;
   logic                empty;
   logic [CNTW-1:0]     count;

   // First valid requester at or after the round-robin pointer, wrapping.
   always_comb begin
      rr_idx = rr_ptr_q;
      rr_hit = 1'b0;
      cand   = '0;
      for (int unsigned k = 0; k < NUM_REQS; k++) begin
         cand = REQ_SELW'((32'(rr_ptr_q) + k) % NUM_REQS);
         if (!rr_hit && bus.req_valid[cand]) begin
            rr_idx = cand;
            rr_hit = 1'b1;
         end
      end
   end

   // Credit comes from the registered count only, so a same-cycle pop never frees a slot.
   always_comb begin
      sel_idx        = locked_q ? lock_idx_q : rr_idx;
      credit_ok      = (count != CNTW'(MAX_INFLIGHT));
      pe_req_valid_c = !reset && credit_ok && bus.req_valid[sel_idx];
      req_fire       = pe_req_valid_c && bus.pe_req_ready;
      next_ptr       = (sel_idx == REQ_SELW'(NUM_REQS - 1)) ? '0 : sel_idx + REQ_SELW'(1);
   end

   // Request-side outputs: granted payload and per-block accept.
   always_comb begin
      bus.pe_req_valid = pe_req_valid_c;
      bus.pe_req_data  = '0;
      bus.req_ready    = '0;
      for (int unsigned i = 0; i < NUM_REQS; i++) begin
         if (sel_idx == REQ_SELW'(i)) begin
            bus.pe_req_data  = bus.req_data[i*DATAW +: DATAW];
            bus.req_ready[i] = req_fire;
         end
      end
   end

   // Response steering to the block at the head of the tag FIFO.
   always_comb begin
      rsp_ok         = !reset && !empty;
      pe_rsp_ready_c = rsp_ok && bus.rsp_ready[head];
      rsp_fire       = bus.pe_rsp_valid && pe_rsp_ready_c;
      bus.rsp_valid  = '0;
      for (int unsigned i = 0; i < NUM_REQS; i++) begin
         bus.rsp_valid[i] = rsp_ok && bus.pe_rsp_valid && (head == REQ_SELW'(i));
      end
      bus.pe_rsp_ready = pe_rsp_ready_c;
      bus.rsp_data     = bus.pe_rsp_data;
      bus.perf_stalls  = perf_q;
   end

   // Grant lock, pointer advance and saturating stall counter.
   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      locked_d   = locked_q;
      lock_idx_d = lock_idx_q;
      perf_d     = perf_q;
      if (req_fire) begin
         rr_ptr_d = next_ptr;
         locked_d = 1'b0;
      end else if (pe_req_valid_c) begin
         locked_d   = 1'b1;
         lock_idx_d = sel_idx;
      end
      if ((|bus.req_valid) && !req_fire && (perf_q != '1)) begin
         perf_d = perf_q + PERF_W'(1);
      end
   end

   // Arbiter state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q   <= '0;
         locked_q   <= 1'b0;
         lock_idx_q <= '0;
         perf_q     <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         locked_q   <= locked_d;
         lock_idx_q <= lock_idx_d;
         perf_q     <= perf_d;
      end
   end

   alu_dot8_share_arb_fifo #(
      .WIDTH (REQ_SELW),
      .DEPTH (MAX_INFLIGHT)
   ) u_tag_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (req_fire),
      .pop_i   (rsp_fire),
      .data_i  (sel_idx),
      .data_o  (head),
      .empty_o (empty),
      .count_o (count)
   );

`ifndef SYNTHESIS
   // A DOT8 result with nothing outstanding has no owner to be steered to.
   rsp_without_tag: assert property (@(posedge clk) disable iff (reset)
      !(bus.pe_rsp_valid && empty))
      else $error("pe_rsp_valid asserted with no outstanding tag");
`endif

endmodule
